clock_divider_prog: RTL and testbench

Parametrised, runtime-programmable successor to the fixed power-of-two clock divider. It generates a free-running binary tap bus (divide-by-2, 4, ... 2^TAPS) and an integer-N divided clock with near-50% duty. A single-cycle period tick accompanies the divided clock. Ratio changes apply glitch-free at period boundaries. Everything runs in the single clk domain, and outputs are registered for use as clock enables or slow strobes.

---
 rtl/clock_divider_prog_if.sv | 24 ++
 rtl/clock_divider_prog.sv | 76 +++++++
 tb/tb_clock_divider_prog.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/clock_divider_prog_if.sv
// rtl/clock_divider_prog_if.sv - control and output bundle of the programmable clock divider
interface clock_divider_prog_if #(
  parameter int W    = 8,
  parameter int TAPS = 4
);
  logic            en;
  logic [W-1:0]    div_val;
  logic            div_load;
  logic            clk_div;
  logic            tick;
  logic [TAPS-1:0] div_taps;
  logic [W-1:0]    cur_div;
  logic            load_pending;

  modport master (
    output en, div_val, div_load,
    input  clk_div, tick, div_taps, cur_div, load_pending
  );

  modport slave (
    input  en, div_val, div_load,
    output clk_div, tick, div_taps, cur_div, load_pending
  );
endinterface

// File: rtl/clock_divider_prog.sv
// rtl/clock_divider_prog.sv - binary tap divider plus runtime-programmable integer-N divider
module clock_divider_prog #(
  parameter int W         = 8,
  parameter int TAPS      = 4,
  parameter int DIV_RESET = 2
) (
  input logic                 i_clk,
  input logic                 i_rst,
  clock_divider_prog_if.slave bus
);

  localparam logic [W-1:0] DIV_RST = W'(DIV_RESET);

  function automatic logic [W-1:0] clamp2(input logic [W-1:0] v);
    return (v < W'(2)) ? W'(2) : v;
  endfunction

  logic [W-1:0]    r_pcnt;
  logic [TAPS-1:0] r_tap;
  logic [W-1:0]    r_cur;
  logic [W-1:0]    r_pend;
  logic            r_pend_v;
  logic            r_clk_div;
  logic            r_tick;

  logic [W-1:0]    w_load_val;
  logic            w_last;
  logic            w_apply;
  logic [W-1:0]    w_cur_next;
  logic [W-1:0]    w_pcnt_next;
  logic [W:0]      w_half;
  logic            w_clk_next;

  assign w_load_val  = clamp2(bus.div_val);
  assign w_last      = (r_pcnt == r_cur - W'(1));
  // A same-cycle strobe at the boundary takes priority over the stored value.
  assign w_apply     = bus.en & w_last & (bus.div_load | r_pend_v);
  assign w_cur_next  = w_apply ? (bus.div_load ? w_load_val : r_pend) : r_cur;
  assign w_pcnt_next = bus.en ? (w_last ? '0 : r_pcnt + W'(1)) : r_pcnt;
  // One extra bit so the half-period of the largest ratio does not overflow.
  assign w_half      = ({1'b0, w_cur_next} + (W+1)'(1)) >> 1;
  assign w_clk_next  = ({1'b0, w_pcnt_next} < w_half);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pcnt    <= DIV_RST - W'(1);
      r_tap     <= '0;
      r_cur     <= DIV_RST;
      r_pend    <= DIV_RST;
      r_pend_v  <= 1'b0;
      r_clk_div <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_tick <= bus.en & (w_pcnt_next == '0);
      if (bus.en) begin
        r_pcnt    <= w_pcnt_next;
        r_tap     <= r_tap + TAPS'(1);
        r_cur     <= w_cur_next;
        r_clk_div <= w_clk_next;
      end
      if (w_apply) begin
        r_pend_v <= 1'b0;
      end else if (bus.div_load) begin
        r_pend   <= w_load_val;
        r_pend_v <= 1'b1;
      end
    end
  end

  assign bus.clk_div      = r_clk_div;
  assign bus.tick         = r_tick;
  assign bus.div_taps     = r_tap;
  assign bus.cur_div      = r_cur;
  assign bus.load_pending = r_pend_v;

endmodule

// File: tb/tb_clock_divider_prog.sv
// tb/tb_clock_divider_prog.sv - scoreboard bench for clock_divider_prog
module tb_clock_divider_prog;

  logic clk;
  logic rst;
  int   cycle_no;
  int   checks;
  int   failures;
  logic [3:0] exp_tap;
  string tag;

  typedef struct {
    int         cyc;
    logic       clk_div;
    logic       tick;
    logic [3:0] taps;
    logic [7:0] cur;
    logic       pend;
    string      tag;
  } exp_t;

  exp_t sb[$];

  clock_divider_prog_if #(.W(8), .TAPS(4)) bus();

  clock_divider_prog #(.W(8), .TAPS(4), .DIV_RESET(2)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycle_no = 0;
  always @(posedge clk) cycle_no <= cycle_no + 1;

  task automatic push(input logic c, input logic t, input logic [7:0] cur, input logic p);
    exp_t e;
    e.cyc     = cycle_no + 1;
    e.clk_div = c;
    e.tick    = t;
    e.taps    = exp_tap;
    e.cur     = cur;
    e.pend    = p;
    e.tag     = tag;
    sb.push_back(e);
  endtask

  // Drive one cycle of inputs and queue what the outputs must show after that edge.
  task automatic step(input logic e, input logic ld, input logic [7:0] v,
                      input logic ec, input logic et, input logic [7:0] ecur, input logic ep);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.en       = e;
    bus.div_load = ld;
    bus.div_val  = v;
    if (e) exp_tap = exp_tap + 4'd1;
    push(ec, et, ecur, ep);
  endtask

  task automatic do_reset(input logic e, input logic ld, input logic [7:0] v);
    @(posedge clk);
    #1;
    rst          = 1'b1;
    bus.en       = e;
    bus.div_load = ld;
    bus.div_val  = v;
    exp_tap      = 4'd0;
    push(1'b0, 1'b0, 8'd2, 1'b0);
  endtask

  task automatic per_tail(input int n, input int k0, input logic ep);
    for (int k = k0; k < n; k++)
      step(1'b1, 1'b0, 8'd0, logic'(k < (n + 1) / 2), logic'(k == 0), 8'(n), ep);
  endtask

  task automatic per(input int n);
    per_tail(n, 0, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cycle_no) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc != cycle_no || bus.clk_div !== e.clk_div || bus.tick !== e.tick ||
          bus.div_taps !== e.taps || bus.cur_div !== e.cur || bus.load_pending !== e.pend) begin
        failures++;
        $display("FAIL %s cyc=%0d/%0d got clk_div=%b tick=%b taps=%0d cur=%0d pend=%b exp clk_div=%b tick=%b taps=%0d cur=%0d pend=%b",
                 e.tag, cycle_no, e.cyc, bus.clk_div, bus.tick, bus.div_taps, bus.cur_div,
                 bus.load_pending, e.clk_div, e.tick, e.taps, e.cur, e.pend);
      end
    end
  end

  initial begin
    repeat (5000) @(posedge clk);
    failures++;
    $display("FAIL watchdog cycles=%0d exceeded limit=5000", cycle_no);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    checks       = 0;
    failures     = 0;
    exp_tap      = 4'd0;
    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.div_load = 1'b0;
    bus.div_val  = 8'd0;

    tag = "reset";
    do_reset(1'b1, 1'b1, 8'd9);

    tag = "div2_taps";
    for (int i = 0; i < 16; i++) per(2);

    tag = "load5_mid";
    step(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 8'd2, 1'b0);
    step(1'b1, 1'b1, 8'd5, 1'b0, 1'b0, 8'd2, 1'b1);
    for (int i = 0; i < 3; i++) per(5);

    tag = "load7_then4";
    step(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 8'd5, 1'b0);
    step(1'b1, 1'b1, 8'd7, 1'b1, 1'b0, 8'd5, 1'b1);
    step(1'b1, 1'b1, 8'd4, 1'b1, 1'b0, 8'd5, 1'b1);
    step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd5, 1'b1);
    step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd5, 1'b1);
    for (int i = 0; i < 2; i++) per(4);

    tag = "load0_then1";
    step(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 8'd4, 1'b0);
    step(1'b1, 1'b1, 8'd0, 1'b1, 1'b0, 8'd4, 1'b1);
    step(1'b1, 1'b1, 8'd1, 1'b0, 1'b0, 8'd4, 1'b1);
    step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd4, 1'b1);
    for (int i = 0; i < 2; i++) per(2);

    tag = "load6_boundary";
    step(1'b1, 1'b1, 8'd6, 1'b1, 1'b1, 8'd6, 1'b0);
    per_tail(6, 1, 1'b0);
    per(6);

    tag = "en_pause";
    step(1'b1, 1'b1, 8'd5, 1'b1, 1'b1, 8'd5, 1'b0);
    step(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 8'd5, 1'b0);
    for (int i = 0; i < 10; i++)
      step(1'b0, logic'(i == 4), 8'd3, 1'b1, 1'b0, 8'd5, logic'(i >= 4));
    per_tail(5, 2, 1'b1);
    per(3);

    tag = "reset_mid";
    step(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 8'd3, 1'b0);
    step(1'b1, 1'b1, 8'd9, 1'b1, 1'b0, 8'd3, 1'b1);
    do_reset(1'b1, 1'b1, 8'd7);
    for (int i = 0; i < 2; i++) per(2);

    tag = "div255";
    step(1'b1, 1'b1, 8'd255, 1'b1, 1'b1, 8'd255, 1'b0);
    per_tail(255, 1, 1'b0);
    per(255);

    tag = "drain";
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending_entries=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
